// File: rtl/l2_block_responder.sv
// L2 block responder: moves whole cache blocks between an L1 miss-repair
// handshake interface and a single-port synchronous SRAM, one word per beat.
module l2_block_responder #(
  parameter int BLOCK_WORDS = 32,
  parameter int MEM_AW      = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [31:0]       wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [31:0]       rdata,
  output logic              rdata_last,
  output logic              req_done,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int BW    = $clog2(BLOCK_WORDS);
  localparam int TAG_W = MEM_AW - BW;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BLOCK_WORDS - 1);
  localparam logic [BW-1:0] ONE_BEAT  = BW'(1);
  localparam logic [BW-1:0] ZERO_BEAT = BW'(0);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WRITE      = 3'd1,
    RD_FETCH   = 3'd2,
    RD_CAPTURE = 3'd3,
    RD_SEND    = 3'd4,
    DONE       = 3'd5
  } state_t;

  state_t            state_r, state_s;
  logic [TAG_W-1:0]  blk_r, blk_s;
  logic [BW-1:0]     beat_r, beat_s;
  logic [31:0]       rdata_r, rdata_s;
  logic              last_beat_s;
  logic              unused_s;

  // The block index sits above the beat bits, so base+beat can never carry out.
  assign mem_addr    = {blk_r, beat_r};
  assign rdata       = rdata_r;
  assign last_beat_s = (beat_r == LAST_BEAT);
  assign unused_s    = ^{req_addr[31:MEM_AW+2], req_addr[BW+1:0]};

  // State, block index, beat counter and read-data holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      blk_r   <= {TAG_W{1'b0}};
      beat_r  <= ZERO_BEAT;
      rdata_r <= 32'd0;
    end else begin
      state_r <= state_s;
      blk_r   <= blk_s;
      beat_r  <= beat_s;
      rdata_r <= rdata_s;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_s     = state_r;
    blk_s       = blk_r;
    beat_s      = beat_r;
    rdata_s     = rdata_r;
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    rdata_valid = 1'b0;
    rdata_last  = 1'b0;
    req_done    = 1'b0;
    busy        = (state_r != IDLE);
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = 32'd0;
    case (state_r)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          blk_s   = req_addr[MEM_AW+1:BW+2];
          beat_s  = ZERO_BEAT;
          state_s = req_write ? WRITE : RD_FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        wdata_ready = 1'b1;
        if (wdata_valid) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_wdata = wdata;
          if (last_beat_s) begin
            state_s = DONE;
          end else begin
            beat_s = beat_r + ONE_BEAT;
          end
        end else begin
          state_s = WRITE;
        end
      end
      RD_FETCH: begin
        mem_en  = 1'b1;
        state_s = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        rdata_s = mem_rdata;
        state_s = RD_SEND;
      end
      RD_SEND: begin
        rdata_valid = 1'b1;
        rdata_last  = last_beat_s;
        if (rdata_ready) begin
          if (last_beat_s) begin
            state_s = DONE;
          end else begin
            beat_s  = beat_r + ONE_BEAT;
            state_s = RD_FETCH;
          end
        end else begin
          state_s = RD_SEND;
        end
      end
      DONE: begin
        req_done = 1'b1;
        state_s  = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_l2_block_responder.sv
// Self-checking bench for l2_block_responder: an SRAM model plus a word-level
// reference memory predicting every write address and every read beat.
module tb_l2_block_responder;

  localparam int BW = 32;
  localparam int AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, req_valid, req_ready, req_write;
  logic [31:0]   req_addr;
  logic          wdata_valid, wdata_ready;
  logic [31:0]   wdata;
  logic          rdata_valid, rdata_ready;
  logic [31:0]   rdata;
  logic          rdata_last, req_done, busy, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  l2_block_responder #(.BLOCK_WORDS(BW), .MEM_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata), .rdata_last(rdata_last),
    .req_done(req_done), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  bit [31:0]   sram    [0:(1<<AW)-1];
  bit [31:0]   ref_mem [0:(1<<AW)-1];
  int          wlog_a[$];
  logic [31:0] wlog_d[$];
  int          cyc = 0;
  int          rd_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] wbuf [0:BW-1];

  // SRAM model with a log of every write and a count of every read
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) begin
        sram[mem_addr] <= mem_wdata;
        wlog_a.push_back(int'(mem_addr));
        wlog_d.push_back(mem_wdata);
      end else begin
        mem_rdata <= sram[mem_addr];
        rd_cnt    <= rd_cnt + 1;
      end
    end
  end

  // first word index of the block holding a byte address
  function automatic int blk_base(input logic [31:0] addr);
    return ((int'(addr >> 2) % (1 << AW)) / BW) * BW;
  endfunction

  task automatic do_write(input logic [31:0] addr, input int mode, input string nm);
    int base, beat, ncyc, ws;
    logic v;
    base = blk_base(addr);
    ws   = wlog_a.size();
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_accept req_ready=%b busy=%b exp 1/0", nm, req_ready, busy);
    end
    beat = 0; ncyc = 0;
    while (beat < BW && ncyc < 500) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      case (mode)
        1:       v = (ncyc % 2 == 0);
        2:       v = 1'($urandom_range(0, 1));
        default: v = 1'b1;
      endcase
      wdata_valid = v;
      wdata       = wbuf[beat];
      @(negedge clk);
      ncyc++;
      n_tests++;
      if (wdata_ready !== 1'b1 || busy !== 1'b1 || req_ready !== 1'b0) begin
        n_fail++; $display("FAIL %s_wstate wdata_ready=%b busy=%b req_ready=%b exp 1/1/0", nm, wdata_ready, busy, req_ready);
      end
      n_tests++;
      if (mem_en !== v || mem_we !== v) begin
        n_fail++; $display("FAIL %s_mem_en beat=%0d mem_en=%b mem_we=%b exp %b", nm, beat, mem_en, mem_we, v);
      end
      if (v) beat++;
    end
    @(posedge clk); #1;
    wdata_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (req_done !== 1'b1 || mem_en !== 1'b0) begin
      n_fail++; $display("FAIL %s_done req_done=%b mem_en=%b exp 1/0", nm, req_done, mem_en);
    end
    if (mode == 0) begin
      n_tests++;
      if (ncyc != BW) begin
        n_fail++; $display("FAIL %s_cycles got=%0d exp=%0d", nm, ncyc, BW);
      end
    end
    n_tests++;
    if (wlog_a.size() - ws != BW) begin
      n_fail++; $display("FAIL %s_nwrites got=%0d exp=%0d", nm, wlog_a.size() - ws, BW);
    end
    for (int i = 0; i < BW; i++) begin
      ref_mem[base + i] = wbuf[i];
      if (ws + i < wlog_a.size()) begin
        n_tests++;
        if (wlog_a[ws + i] != base + i || wlog_d[ws + i] !== wbuf[i]) begin
          n_fail++; $display("FAIL %s_wlog i=%0d addr=%h data=%h exp addr=%h data=%h",
                             nm, i, wlog_a[ws + i], wlog_d[ws + i], base + i, wbuf[i]);
        end
      end
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int stall_beat, input int stall_len,
                         input bit hold, input string nm);
    int base, i, guard, c0, last_acc, stall_left, ws, rs;
    bit seen;
    logic [31:0] held;
    base = blk_base(addr);
    ws   = wlog_a.size();
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || req_done !== 1'b0) begin
      n_fail++; $display("FAIL %s_accept req_ready=%b busy=%b req_done=%b exp 1/0/0", nm, req_ready, busy, req_done);
    end
    c0 = cyc; rs = rd_cnt;
    i = 0; guard = 0; seen = 1'b0; stall_left = stall_len; last_acc = c0; held = 32'd0;
    while (i < BW && guard < 1000) begin
      @(posedge clk); #1;
      req_valid   = hold;
      wdata_valid = 1'($urandom_range(0, 1));
      rdata_ready = (i == stall_beat && stall_left > 0) ? 1'b0 : 1'b1;
      @(negedge clk);
      guard++;
      n_tests++;
      if (req_ready !== 1'b0 || busy !== 1'b1 || mem_we !== 1'b0) begin
        n_fail++; $display("FAIL %s_busy req_ready=%b busy=%b mem_we=%b exp 0/1/0", nm, req_ready, busy, mem_we);
      end
      if (rdata_valid === 1'b1) begin
        n_tests++;
        if (rdata_last !== (i == BW - 1)) begin
          n_fail++; $display("FAIL %s_last beat=%0d got=%b exp=%b", nm, i, rdata_last, (i == BW - 1));
        end
        if (!seen) begin
          n_tests++;
          if (rdata !== ref_mem[base + i]) begin
            n_fail++; $display("FAIL %s_rdata beat=%0d got=%h exp=%h", nm, i, rdata, ref_mem[base + i]);
          end
          n_tests++;
          if (cyc - last_acc != 3) begin
            n_fail++; $display("FAIL %s_latency beat=%0d got=%0d exp=3", nm, i, cyc - last_acc);
          end
          seen = 1'b1;
          held = rdata;
        end else begin
          n_tests++;
          if (rdata !== held || mem_en !== 1'b0) begin
            n_fail++; $display("FAIL %s_stall beat=%0d rdata=%h mem_en=%b exp %h/0", nm, i, rdata, mem_en, held);
          end
        end
        if (rdata_ready) begin
          i++; seen = 1'b0; last_acc = cyc;
        end else begin
          stall_left--;
        end
      end
    end
    n_tests++;
    if (i < BW) begin
      n_fail++; $display("FAIL %s_timeout beats=%0d exp=%0d", nm, i, BW);
    end
    @(posedge clk); #1;
    wdata_valid = 1'b0; rdata_ready = 1'b0; req_valid = hold;
    @(negedge clk);
    n_tests++;
    if (req_done !== 1'b1 || rdata_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++; $display("FAIL %s_done req_done=%b rdata_valid=%b req_ready=%b exp 1/0/0", nm, req_done, rdata_valid, req_ready);
    end
    n_tests++;
    if (rd_cnt - rs != BW || wlog_a.size() != ws) begin
      n_fail++; $display("FAIL %s_memops reads=%0d writes=%0d exp %0d/0", nm, rd_cnt - rs, wlog_a.size() - ws, BW);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({req_ready, wdata_ready, rdata_valid, rdata_last, req_done, busy, mem_en, mem_we} !== 8'b1000_0000) begin
      n_fail++; $display("FAIL reset_outputs got=%b exp=10000000",
                         {req_ready, wdata_ready, rdata_valid, rdata_last, req_done, busy, mem_en, mem_we});
    end
    n_tests++;
    if (rdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_rdata got=%h exp=0", rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_write_basic();
    for (int i = 0; i < BW; i++) wbuf[i] = 32'h1000 + i;
    do_write(32'h0000_0280, 0, "wr_basic");
  endtask

  task automatic test_read_basic();
    do_read(32'h0000_02A4, -1, 0, 1'b0, "rd_basic");
  endtask

  task automatic test_read_stall();
    do_read(32'h0000_02A4, 3, 5, 1'b0, "rd_stall");
  endtask

  task automatic test_write_toggle();
    for (int i = 0; i < BW; i++) wbuf[i] = $urandom;
    do_write(32'h0000_1F00, 1, "wr_toggle");
    do_read(32'h0000_1F3C, -1, 0, 1'b0, "rd_toggle");
  endtask

  task automatic test_back_to_back();
    do_read(32'h0000_0280, -1, 0, 1'b1, "b2b_first");
    do_read(32'h0000_1F00, -1, 0, 1'b0, "b2b_second");
  endtask

  task automatic test_reset_mid_write();
    int base, ws;
    bit [31:0] snap [0:BW-1];
    base = blk_base(32'h0000_0300);
    ws   = wlog_a.size();
    for (int i = 0; i < BW; i++) begin
      wbuf[i] = $urandom;
      snap[i] = sram[base + i];
    end
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0300;
    for (int b = 0; b <= 10; b++) begin
      @(posedge clk); #1;
      req_valid = 1'b0; wdata_valid = 1'b1; wdata = wbuf[b];
    end
    @(posedge clk); #1;
    wdata_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; wdata_valid = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || mem_en !== 1'b0 || rdata !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid_state busy=%b req_ready=%b mem_en=%b rdata=%h exp 0/1/0/0", busy, req_ready, mem_en, rdata);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      wdata_valid = 1'($urandom_range(0, 1)); rdata_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_tests++;
      if (mem_en !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_quiet cycle=%0d mem_en=%b exp=0", k, mem_en);
      end
    end
    wdata_valid = 1'b0; rdata_ready = 1'b0;
    n_tests++;
    if (wlog_a.size() - ws != 11) begin
      n_fail++; $display("FAIL rst_mid_nwrites got=%0d exp=11", wlog_a.size() - ws);
    end
    for (int i = 0; i < BW; i++) begin
      if (i <= 10) ref_mem[base + i] = wbuf[i];
      else         ref_mem[base + i] = snap[i];
      n_tests++;
      if (sram[base + i] !== ref_mem[base + i]) begin
        n_fail++; $display("FAIL rst_mid_word i=%0d got=%h exp=%h", i, sram[base + i], ref_mem[base + i]);
      end
    end
    do_read(32'h0000_0300, -1, 0, 1'b0, "rd_after_rst");
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int k = 0; k < 6; k++) begin
      addr = $urandom;
      for (int i = 0; i < BW; i++) wbuf[i] = $urandom;
      do_write(addr, int'($urandom_range(0, 2)), "rnd_wr");
      do_read({addr[31:7], 7'($urandom_range(0, 127))}, int'($urandom_range(0, BW - 1)),
              int'($urandom_range(1, 4)), 1'b0, "rnd_rd");
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0;
    wdata_valid = 1'b0; wdata = 32'd0; rdata_ready = 1'b0;
    test_reset();
    test_write_basic();
    test_read_basic();
    test_read_stall();
    test_write_toggle();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
